// File: rtl/blockrom_arbiter.sv
// Two-port arbiter/sequencer for the 64 KB boot block RAM: round-robin grant,
// range/permission checks and in-order tagged responses through a 2-entry FIFO.
module blockrom_arbiter #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned MEM_AW = 16,
  parameter int unsigned DATA_W = 128
) (
  input  logic                clka,
  input  logic                rsta_n,
  input  logic [1:0]          rq_valid,
  output logic [1:0]          rq_ready,
  input  logic [ADDR_W-1:0]   rq_addr0,
  input  logic [ADDR_W-1:0]   rq_addr1,
  input  logic [DATA_W-1:0]   rq_wdata1,
  input  logic [DATA_W/8-1:0] rq_wstrb0,
  input  logic [DATA_W/8-1:0] rq_wstrb1,
  output logic [1:0]          rs_valid,
  input  logic [1:0]          rs_ready,
  output logic [DATA_W-1:0]   rs_rdata,
  output logic                rs_err,
  output logic                mem_ena,
  output logic [DATA_W/8-1:0] mem_wea,
  output logic [ADDR_W-1:0]   mem_addra,
  output logic [DATA_W-1:0]   mem_dina,
  input  logic [DATA_W-1:0]   mem_douta
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(STRB_W - 1);

  typedef struct packed {
    logic              id;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic             last_grant_q, last_grant_d;
  logic             infl_vld_q, infl_vld_d;
  logic             infl_id_q, infl_id_d;
  logic             infl_wr_q, infl_wr_d;
  logic             hold_vld_q, hold_vld_d;
  logic             hold_id_q, hold_id_d;
  rsp_t [1:0]       fifo_q, fifo_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  rsp_t             head;
  rsp_t             push_ent;
  logic             pop;
  logic [1:0]       occ;
  logic             can_accept;
  logic             grant;
  logic             accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [STRB_W-1:0] sel_strb;
  logic             req_err;
  logic             issue;
  logic             err_acc;
  logic             first_vld;
  logic             push;

  // Response side: FIFO head drives the shared response bus.
  always_comb begin
    head     = fifo_q[rd_ptr_q];
    rs_valid = 2'b00;
    rs_rdata = '0;
    rs_err   = 1'b0;
    if (cnt_q != 2'd0) begin
      rs_valid = head.id ? 2'b10 : 2'b01;
      rs_rdata = head.data;
      rs_err   = head.err;
    end
    pop = |(rs_valid & rs_ready);
  end

  // Arbitration, request checks and memory drive for the accepted request.
  always_comb begin
    occ        = cnt_q + 2'(infl_vld_q) + 2'(hold_vld_q);
    can_accept = rsta_n & ((occ < 2'd2) | pop);
    grant      = rq_valid[1] & (~rq_valid[0] | ~last_grant_q);
    rq_ready   = 2'b00;
    if (can_accept) begin
      rq_ready = grant ? 2'b10 : 2'b01;
    end
    accept    = |(rq_valid & rq_ready);
    sel_addr  = grant ? rq_addr1 : rq_addr0;
    sel_strb  = grant ? rq_wstrb1 : rq_wstrb0;
    req_err   = (|sel_addr[ADDR_W-1:MEM_AW]) | (~grant & (|sel_strb));
    issue     = accept & ~req_err;
    err_acc   = accept & req_err;
    mem_ena   = issue;
    mem_wea   = '0;
    mem_addra = '0;
    mem_dina  = '0;
    if (issue) begin
      mem_wea   = sel_strb;
      mem_addra = sel_addr & LINE_MASK;
      mem_dina  = grant ? rq_wdata1 : '0;
    end
  end

  // Push ordering: capture (or a held error) is older than a new error request.
  always_comb begin
    first_vld = infl_vld_q | hold_vld_q;
    push      = first_vld | err_acc;
    push_ent  = '0;
    if (infl_vld_q) begin
      push_ent.id   = infl_id_q;
      push_ent.err  = 1'b0;
      push_ent.data = infl_wr_q ? '0 : mem_douta;
    end else if (hold_vld_q) begin
      push_ent.id  = hold_id_q;
      push_ent.err = 1'b1;
    end else begin
      push_ent.id  = grant;
      push_ent.err = 1'b1;
    end

    hold_vld_d   = first_vld & err_acc;
    hold_id_d    = grant;
    infl_vld_d   = issue;
    infl_id_d    = grant;
    infl_wr_d    = |sel_strb;
    last_grant_d = accept ? grant : last_grant_q;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_ent;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      last_grant_q <= 1'b1;
      infl_vld_q   <= 1'b0;
      infl_id_q    <= 1'b0;
      infl_wr_q    <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_id_q    <= 1'b0;
      fifo_q       <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
    end else begin
      last_grant_q <= last_grant_d;
      infl_vld_q   <= infl_vld_d;
      infl_id_q    <= infl_id_d;
      infl_wr_q    <= infl_wr_d;
      hold_vld_q   <= hold_vld_d;
      hold_id_q    <= hold_id_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_blockrom_arbiter.sv
// Bench for blockrom_arbiter: directed vector table, hand sequences and random
// traffic checked against a transaction-level queue model with a shadow memory.
module tb_blockrom_arbiter;

  logic         clka;
  logic         rsta_n;
  logic [1:0]   rq_valid;
  logic [1:0]   rq_ready;
  logic [19:0]  rq_addr0, rq_addr1;
  logic [127:0] rq_wdata1;
  logic [15:0]  rq_wstrb0, rq_wstrb1;
  logic [1:0]   rs_valid;
  logic [1:0]   rs_ready;
  logic [127:0] rs_rdata;
  logic         rs_err;
  logic         mem_ena;
  logic [15:0]  mem_wea;
  logic [19:0]  mem_addra;
  logic [127:0] mem_dina;
  logic [127:0] mem_douta;

  blockrom_arbiter dut (
    .clka(clka), .rsta_n(rsta_n),
    .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_wdata1(rq_wdata1), .rq_wstrb0(rq_wstrb0), .rq_wstrb1(rq_wstrb1),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_rdata(rs_rdata), .rs_err(rs_err),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  function automatic logic [127:0] img(input int i);
    return {32'hA5A50000 ^ 32'(i), 32'(i * 7 + 3), 32'hC0DE0000 | 32'(i), ~32'(i)};
  endfunction

  // Block RAM device: registered read, byte-enabled write, image loaded once.
  logic [127:0] dev_mem [4096];
  bit           loaded = 1'b0;
  always @(posedge clka) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) dev_mem[i] <= img(i);
      loaded <= 1'b1;
    end else if (mem_ena) begin
      for (int b = 0; b < 16; b++)
        if (mem_wea[b]) dev_mem[mem_addra[15:4]][b*8 +: 8] <= mem_dina[b*8 +: 8];
      mem_douta <= dev_mem[mem_addra[15:4]];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: accepted-but-unconsumed responses with visibility cycle.
  typedef struct {
    bit           id;
    bit           err;
    logic [127:0] data;
    int           vis;
  } exp_t;

  exp_t         q[$];
  logic [127:0] ref_mem [4096];
  bit           m_last = 1'b1;
  int           m_last_push = -10;
  int           cyc = 0;

  task automatic model_step();
    bit           hv, pop, can, g, acc, bad, legal;
    logic [1:0]   e_rsv, e_rdy;
    logic [19:0]  addr;
    logic [15:0]  strb;
    logic [127:0] d;
    int           p;
    exp_t         e;
    if (!rsta_n) begin
      chk("rst_ctrl", 128'({rq_ready, rs_valid, rs_err, mem_ena, mem_wea}), 128'(0));
      chk("rst_rdata", rs_rdata, 128'(0));
      chk("rst_addr", 128'(mem_addra), 128'(0));
      chk("rst_din", mem_dina, 128'(0));
      q.delete();
      m_last      = 1'b1;
      m_last_push = -10;
    end else begin
      hv    = (q.size() > 0) && (q[0].vis <= cyc);
      e_rsv = 2'b00;
      d     = '0;
      pop   = 1'b0;
      if (hv) begin
        e_rsv = q[0].id ? 2'b10 : 2'b01;
        d     = q[0].data;
        pop   = rs_ready[q[0].id];
      end
      chk("m_rs_valid", 128'(rs_valid), 128'(e_rsv));
      chk("m_rs_err", 128'(rs_err), 128'(hv && q[0].err));
      chk("m_rs_rdata", rs_rdata, d);

      can   = (q.size() < 2) || pop;
      g     = (rq_valid == 2'b11) ? !m_last : rq_valid[1];
      acc   = can && rq_valid[g];
      e_rdy = can ? (g ? 2'b10 : 2'b01) : 2'b00;
      if (rq_valid != 2'b00) chk("m_rq_ready", 128'(rq_ready), 128'(e_rdy));

      addr       = g ? rq_addr1 : rq_addr0;
      addr[3:0]  = 4'h0;
      strb       = g ? rq_wstrb1 : rq_wstrb0;
      bad        = (addr[19:16] != 4'h0) || (!g && strb != 16'h0);
      legal      = acc && !bad;
      chk("m_mem_ena", 128'(mem_ena), 128'(legal));
      chk("m_mem_wea", 128'(mem_wea), 128'(legal ? strb : 16'h0));
      chk("m_mem_addra", 128'(mem_addra), 128'(legal ? addr : 20'h0));
      chk("m_mem_dina", mem_dina, (legal && g) ? rq_wdata1 : 128'h0);

      if (pop) void'(q.pop_front());
      if (acc) begin
        d = '0;
        if (legal && strb != 16'h0) begin
          for (int b = 0; b < 16; b++)
            if (strb[b]) ref_mem[addr[15:4]][b*8 +: 8] = rq_wdata1[b*8 +: 8];
        end else if (legal) begin
          d = ref_mem[addr[15:4]];
        end
        p = legal ? cyc + 1 : cyc;
        if (p <= m_last_push) p = m_last_push + 1;
        m_last_push = p;
        e.id   = g;
        e.err  = !legal;
        e.data = d;
        e.vis  = p + 1;
        q.push_back(e);
        m_last = g;
      end
    end
    cyc++;
  endtask

  // Staged stimulus, applied just after the rising edge.
  logic         s_rst_n;
  logic [1:0]   s_valid, s_rs_ready;
  logic [19:0]  s_addr0, s_addr1;
  logic [15:0]  s_wstrb0, s_wstrb1;
  logic [127:0] s_wdata1;

  task automatic tick();
    @(posedge clka);
    #1;
    rsta_n    = s_rst_n;
    rq_valid  = s_valid;
    rq_addr0  = s_addr0;
    rq_addr1  = s_addr1;
    rq_wstrb0 = s_wstrb0;
    rq_wstrb1 = s_wstrb1;
    rq_wdata1 = s_wdata1;
    rs_ready  = s_rs_ready;
    @(negedge clka);
    model_step();
  endtask

  task automatic idle(input int n);
    s_valid    = 2'b00;
    s_rs_ready = 2'b11;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [19:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 20'(($urandom_range(1, 15) << 16) | ($urandom & 32'hFFFF));
    if (r < 4)  return 20'($urandom & 32'hFFFF);
    return 20'(($urandom_range(0, 15) << 4) | ($urandom & 32'hF));
  endfunction

  typedef struct {
    logic [1:0]   v;
    logic [19:0]  a0;
    logic [15:0]  s0;
    logic [19:0]  a1;
    logic [15:0]  s1;
    logic [1:0]   rdy;
    logic         ena;
    logic [1:0]   rsv;
    logic         err;
    logic [127:0] dat;
    logic         cd;
  } vec_t;

  vec_t         tbl[12];
  logic [127:0] t;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = img(i);

    // Tie fairness from reset, single read data, then both error kinds.
    tbl[0]  = '{2'b11, 20'h00010, 16'h0,    20'h00030, 16'h0, 2'b01, 1'b1, 2'b00, 1'b0, 128'h0, 1'b0};
    tbl[1]  = '{2'b11, 20'h00010, 16'h0,    20'h00030, 16'h0, 2'b10, 1'b1, 2'b00, 1'b0, 128'h0, 1'b0};
    tbl[2]  = '{2'b11, 20'h00010, 16'h0,    20'h00030, 16'h0, 2'b01, 1'b1, 2'b01, 1'b0, img(1), 1'b1};
    tbl[3]  = '{2'b11, 20'h00010, 16'h0,    20'h00030, 16'h0, 2'b10, 1'b1, 2'b10, 1'b0, img(3), 1'b1};
    tbl[4]  = '{2'b11, 20'h00010, 16'h0,    20'h00030, 16'h0, 2'b01, 1'b1, 2'b01, 1'b0, 128'h0, 1'b0};
    tbl[5]  = '{2'b11, 20'h00010, 16'h0,    20'h00030, 16'h0, 2'b10, 1'b1, 2'b10, 1'b0, 128'h0, 1'b0};
    tbl[6]  = '{2'b00, 20'h00010, 16'h0,    20'h00030, 16'h0, 2'b00, 1'b0, 2'b01, 1'b0, 128'h0, 1'b0};
    tbl[7]  = '{2'b00, 20'h00010, 16'h0,    20'h00030, 16'h0, 2'b00, 1'b0, 2'b10, 1'b0, 128'h0, 1'b0};
    tbl[8]  = '{2'b01, 20'h00010, 16'h0001, 20'h00030, 16'h0, 2'b01, 1'b0, 2'b00, 1'b0, 128'h0, 1'b0};
    tbl[9]  = '{2'b10, 20'h00010, 16'h0,    20'h10000, 16'h0, 2'b10, 1'b0, 2'b01, 1'b1, 128'h0, 1'b1};
    tbl[10] = '{2'b00, 20'h00010, 16'h0,    20'h10000, 16'h0, 2'b00, 1'b0, 2'b10, 1'b1, 128'h0, 1'b1};
    tbl[11] = '{2'b00, 20'h00010, 16'h0,    20'h10000, 16'h0, 2'b00, 1'b0, 2'b00, 1'b0, 128'h0, 1'b0};

    rsta_n = 1'b0; rq_valid = 2'b00; rq_addr0 = '0; rq_addr1 = '0;
    rq_wstrb0 = '0; rq_wstrb1 = '0; rq_wdata1 = '0; rs_ready = 2'b00;
    s_rst_n = 1'b0; s_valid = 2'b00; s_addr0 = '0; s_addr1 = '0;
    s_wstrb0 = '0; s_wstrb1 = '0; s_wdata1 = '0; s_rs_ready = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    s_rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      s_valid  = tbl[i].v;  s_addr0 = tbl[i].a0; s_wstrb0 = tbl[i].s0;
      s_addr1  = tbl[i].a1; s_wstrb1 = tbl[i].s1; s_rs_ready = 2'b11;
      tick();
      if (tbl[i].v != 2'b00) chk($sformatf("tbl%0d_rq_ready", i), 128'(rq_ready), 128'(tbl[i].rdy));
      chk($sformatf("tbl%0d_mem_ena", i), 128'(mem_ena), 128'(tbl[i].ena));
      chk($sformatf("tbl%0d_rs_valid", i), 128'(rs_valid), 128'(tbl[i].rsv));
      chk($sformatf("tbl%0d_rs_err", i), 128'(rs_err), 128'(tbl[i].err));
      if (tbl[i].cd) chk($sformatf("tbl%0d_rs_rdata", i), rs_rdata, tbl[i].dat);
      if (i == 0) chk("tbl0_mem_addra", 128'(mem_addra), 128'(20'h00010));
    end
    s_wstrb0 = '0;
    idle(2);

    // Port-1 partial write, then read-back of the same line.
    s_valid = 2'b10; s_addr1 = 20'h00020; s_wstrb1 = 16'h000F;
    s_wdata1 = {32'h11112222, 32'h33334444, 32'h55556666, 32'hDEADBEEF};
    tick();
    chk("wr_rq_ready", 128'(rq_ready), 128'(2'b10));
    chk("wr_mem_wea", 128'(mem_wea), 128'(16'h000F));
    s_valid = 2'b00; tick();
    s_valid = 2'b10; s_wstrb1 = 16'h0; tick();
    chk("wr_rsp_valid", 128'(rs_valid), 128'(2'b10));
    chk("wr_rsp_data", rs_rdata, 128'h0);
    chk("wr_rsp_err", 128'(rs_err), 128'(0));
    s_valid = 2'b00; tick(); tick();
    t = img(2);
    chk("rb_rs_valid", 128'(rs_valid), 128'(2'b10));
    chk("rb_rs_rdata", rs_rdata, {t[127:32], 32'hDEADBEEF});
    idle(3);

    // Backpressure: two reads fill the slots, third waits for the first pop.
    s_rs_ready = 2'b00; s_valid = 2'b01;
    s_addr0 = 20'h00040; tick(); chk("bp_acc0", 128'(rq_ready), 128'(2'b01));
    s_addr0 = 20'h00050; tick(); chk("bp_acc1", 128'(rq_ready), 128'(2'b01));
    s_addr0 = 20'h00060; tick(); chk("bp_full0", 128'(rq_ready), 128'(2'b00));
    tick();
    chk("bp_full1", 128'(rq_ready), 128'(2'b00));
    chk("bp_hold_valid", 128'(rs_valid), 128'(2'b01));
    s_rs_ready = 2'b11; tick();
    chk("bp_pop_acc", 128'(rq_ready), 128'(2'b01));
    chk("bp_rsp0", rs_rdata, img(4));
    s_valid = 2'b00; tick(); chk("bp_rsp1", rs_rdata, img(5));
    tick();
    chk("bp_rsp2", rs_rdata, img(6));
    chk("bp_rsp2_valid", 128'(rs_valid), 128'(2'b01));
    idle(2);

    // Reset one cycle after an accept discards the in-flight read.
    s_valid = 2'b01; s_addr0 = 20'h00070; tick();
    chk("rst_pre_acc", 128'(rq_ready), 128'(2'b01));
    s_valid = 2'b00; s_rst_n = 1'b0; tick();
    chk("rst_mid_outs", 128'({rq_ready, rs_valid, mem_ena}), 128'(0));
    tick();
    s_rst_n = 1'b1; tick();
    chk("rst_no_stale", 128'(rs_valid), 128'(2'b00));
    s_valid = 2'b01; s_addr0 = 20'h00080; tick();
    chk("rst_post_acc", 128'(rq_ready), 128'(2'b01));
    chk("rst_post_addr", 128'(mem_addra), 128'(20'h00080));
    s_valid = 2'b00; tick();
    chk("rst_post_early", 128'(rs_valid), 128'(2'b00));
    tick();
    chk("rst_post_valid", 128'(rs_valid), 128'(2'b01));
    chk("rst_post_data", rs_rdata, img(8));
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s_valid    = 2'($urandom);
      s_addr0    = rand_addr();
      s_addr1    = rand_addr();
      s_wstrb0   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0;
      s_wstrb1   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'h0;
      s_wdata1   = {$urandom, $urandom, $urandom, $urandom};
      s_rs_ready = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      tick();
    end
    idle(6);
    chk("drain_empty", 128'(rs_valid), 128'(2'b00));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
